// File: rtl/traffic_intersection_scheduler.sv
// traffic_intersection_scheduler: demand-driven NS/EW right-of-way scheduler with min/max green.
// Latency: phase, lights and ped_walk are registered together, one edge after the deciding inputs.
// Backpressure: none, sensors are sampled every cycle; optional walk phase under `define PED_CROSSING_EN.
module traffic_intersection_scheduler #(
   parameter int MIN_GREEN = 8,
   parameter int MAX_GREEN = 32,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int WALK_T    = 6,
   parameter int TW        = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ns_sensor,
   input  logic       ew_sensor,
`ifdef PED_CROSSING_EN
   input  logic       ped_button,
   output logic       ped_walk,
`endif
   output logic [2:0] phase,
   output logic [1:0] ns_light,
   output logic [1:0] ew_light
);

   localparam logic [2:0] AR_TO_NS = 3'b000;
   localparam logic [2:0] NS_G     = 3'b001;
   localparam logic [2:0] NS_Y     = 3'b010;
   localparam logic [2:0] AR_TO_EW = 3'b011;
   localparam logic [2:0] EW_G     = 3'b100;
   localparam logic [2:0] EW_Y     = 3'b101;
   localparam logic [2:0] PED_WALK = 3'b110;

   // Last-cycle timer values for each timed phase, and the green thresholds.
   localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T - 1);
   localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] T_MIN    = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] T_MAX    = TW'(MAX_GREEN - 1);

   logic [2:0]    phase_q, phase_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          ns_req_q, ns_req_d;
   logic          ew_req_q, ew_req_d;
   logic          ped_req_q;
   logic [1:0]    ns_light_q, ns_light_d;
   logic [1:0]    ew_light_q, ew_light_d;
   logic          in_green;

`ifdef PED_CROSSING_EN
   localparam logic [TW-1:0] T_WALK = TW'(WALK_T - 1);
   logic ped_req_d;
   logic served_ns_q, served_ns_d;
   logic ped_walk_q, ped_walk_d;
`else
   // Without the crossing there is never a pedestrian request.
   assign ped_req_q = 1'b0;
`endif

   assign in_green = (phase_q == NS_G) || (phase_q == EW_G);

   // Phase sequencing: timed phases end on their last timer value, greens end on demand.
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         AR_TO_NS: if (timer_q == T_ALLRED) phase_d = NS_G;
         NS_G:     if ((timer_q >= T_MIN) && (ew_req_q || ped_req_q) &&
                       (!ns_sensor || (timer_q >= T_MAX))) phase_d = NS_Y;
         NS_Y:     if (timer_q == T_YELLOW) phase_d = ped_req_q ? PED_WALK : AR_TO_EW;
         AR_TO_EW: if (timer_q == T_ALLRED) phase_d = EW_G;
         EW_G:     if ((timer_q >= T_MIN) && (ns_req_q || ped_req_q) &&
                       (!ew_sensor || (timer_q >= T_MAX))) phase_d = EW_Y;
         EW_Y:     if (timer_q == T_YELLOW) phase_d = ped_req_q ? PED_WALK : AR_TO_NS;
`ifdef PED_CROSSING_EN
         // Hand over to whichever road did not own the yellow before the walk.
         PED_WALK: if (timer_q == T_WALK) phase_d = served_ns_q ? AR_TO_EW : AR_TO_NS;
`endif
         default:  phase_d = AR_TO_NS;
      endcase
   end

   // Phase timer: restarts on every phase change, holds at the max-green cap while green.
   always_comb begin
      if (phase_d != phase_q)
         timer_d = '0;
      else if (in_green && (timer_q >= T_MAX))
         timer_d = timer_q;
      else
         timer_d = timer_q + TW'(1);
   end

   // Demand latches and registered light decode; clearing on green entry beats a same-edge set.
   always_comb begin
      ns_req_d = ns_req_q | (ns_sensor & (phase_q != NS_G));
      if ((phase_d == NS_G) && (phase_q != NS_G)) ns_req_d = 1'b0;
      ew_req_d = ew_req_q | (ew_sensor & (phase_q != EW_G));
      if ((phase_d == EW_G) && (phase_q != EW_G)) ew_req_d = 1'b0;
      ns_light_d = (phase_d == NS_G) ? 2'b01 : (phase_d == NS_Y) ? 2'b10 : 2'b00;
      ew_light_d = (phase_d == EW_G) ? 2'b01 : (phase_d == EW_Y) ? 2'b10 : 2'b00;
`ifdef PED_CROSSING_EN
      ped_req_d = ped_req_q | (ped_button & (phase_q != PED_WALK));
      if ((phase_d == PED_WALK) && (phase_q != PED_WALK)) ped_req_d = 1'b0;
      ped_walk_d  = (phase_d == PED_WALK);
      served_ns_d = (phase_q == NS_Y) ? 1'b1 : (phase_q == EW_Y) ? 1'b0 : served_ns_q;
`endif
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q    <= AR_TO_NS;
         timer_q    <= '0;
         ns_req_q   <= 1'b0;
         ew_req_q   <= 1'b0;
         ns_light_q <= 2'b00;
         ew_light_q <= 2'b00;
`ifdef PED_CROSSING_EN
         ped_req_q   <= 1'b0;
         ped_walk_q  <= 1'b0;
         served_ns_q <= 1'b0;
`endif
      end else begin
         phase_q    <= phase_d;
         timer_q    <= timer_d;
         ns_req_q   <= ns_req_d;
         ew_req_q   <= ew_req_d;
         ns_light_q <= ns_light_d;
         ew_light_q <= ew_light_d;
`ifdef PED_CROSSING_EN
         ped_req_q   <= ped_req_d;
         ped_walk_q  <= ped_walk_d;
         served_ns_q <= served_ns_d;
`endif
      end
   end

   assign phase    = phase_q;
   assign ns_light = ns_light_q;
   assign ew_light = ew_light_q;
`ifdef PED_CROSSING_EN
   assign ped_walk = ped_walk_q;
`endif

endmodule

// File: tb/tb_traffic_intersection_scheduler.sv
// tb_traffic_intersection_scheduler: directed scenarios plus randomized run against a phase-level model.
// Latency: one check point per cycle, 1 time unit after the rising edge.
// Backpressure: not applicable; the bench drives sensor levels and pulses freely.
module tb_traffic_intersection_scheduler;

   localparam int MIN_GREEN = 8;
   localparam int MAX_GREEN = 32;
   localparam int YELLOW_T  = 3;
   localparam int ALLRED_T  = 2;
   localparam int WALK_T    = 6;

   // Phase numbering used by the model (same codes the outputs carry).
   localparam int P_ARNS = 0, P_NSG = 1, P_NSY = 2, P_AREW = 3, P_EWG = 4, P_EWY = 5, P_WALK = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ns_sensor = 1'b0;
   logic       ew_sensor = 1'b0;
   logic       ped_button = 1'b0;
   logic       ped_walk;
   logic [2:0] phase;
   logic [1:0] ns_light, ew_light;

   int total = 0;
   int bad = 0;

   // Model state: current phase, cycles already spent in it, pending demands, last yellow road.
   int m_ph;
   int m_age;
   bit m_nsd, m_ewd, m_pd, m_last_ns;

   always #5 clk = ~clk;

   traffic_intersection_scheduler dut (
      .clk(clk),
      .reset(reset),
      .ns_sensor(ns_sensor),
      .ew_sensor(ew_sensor),
`ifdef PED_CROSSING_EN
      .ped_button(ped_button),
      .ped_walk(ped_walk),
`endif
      .phase(phase),
      .ns_light(ns_light),
      .ew_light(ew_light)
   );

`ifndef PED_CROSSING_EN
   assign ped_walk = 1'b0;
`endif

   function automatic logic [1:0] ns_of(input int ph);
      return (ph == P_NSG) ? 2'b01 : (ph == P_NSY) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [1:0] ew_of(input int ph);
      return (ph == P_EWG) ? 2'b01 : (ph == P_EWY) ? 2'b10 : 2'b00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply reset on one edge; on return the bench sits in cycle 0.
   task automatic do_reset();
      reset = 1'b1;
      ns_sensor = 1'b0;
      ew_sensor = 1'b0;
      ped_button = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic model_reset();
      m_ph = P_ARNS;
      m_age = 0;
      m_nsd = 0;
      m_ewd = 0;
      m_pd = 0;
      m_last_ns = 0;
   endtask

   // Advance the model across one edge given the inputs seen during the current cycle.
   task automatic model_step(input bit ns, input bit ew, input bit pb);
      int nx;
      bool_last: begin end
      nx = m_ph;
      case (m_ph)
         P_ARNS: if (m_age + 1 == ALLRED_T) nx = P_NSG;
         P_NSG:  if (m_age + 1 >= MIN_GREEN && (m_ewd || m_pd) && (!ns || m_age + 1 >= MAX_GREEN)) nx = P_NSY;
         P_NSY:  if (m_age + 1 == YELLOW_T) nx = m_pd ? P_WALK : P_AREW;
         P_AREW: if (m_age + 1 == ALLRED_T) nx = P_EWG;
         P_EWG:  if (m_age + 1 >= MIN_GREEN && (m_nsd || m_pd) && (!ew || m_age + 1 >= MAX_GREEN)) nx = P_EWY;
         P_EWY:  if (m_age + 1 == YELLOW_T) nx = m_pd ? P_WALK : P_ARNS;
         P_WALK: if (m_age + 1 == WALK_T) nx = m_last_ns ? P_AREW : P_ARNS;
         default: nx = P_ARNS;
      endcase
      if (ns && m_ph != P_NSG) m_nsd = 1;
      if (ew && m_ph != P_EWG) m_ewd = 1;
      if (pb && m_ph != P_WALK) m_pd = 1;
      if (nx == P_NSG && m_ph != P_NSG) m_nsd = 0;
      if (nx == P_EWG && m_ph != P_EWG) m_ewd = 0;
      if (nx == P_WALK && m_ph != P_WALK) m_pd = 0;
      if (m_ph == P_NSY) m_last_ns = 1;
      if (m_ph == P_EWY) m_last_ns = 0;
      if (nx != m_ph) m_age = 0;
      else if (m_ph == P_NSG || m_ph == P_EWG) m_age = (m_age + 1 > MAX_GREEN - 1) ? MAX_GREEN - 1 : m_age + 1;
      else m_age = m_age + 1;
      m_ph = nx;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ns_sensor = 1'b1;
      ew_sensor = 1'b1;
      ped_button = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      ns_sensor = 1'b0;
      ew_sensor = 1'b0;
      ped_button = 1'b0;
      total++;
      if (phase !== 3'b000) begin $display("FAIL reset_phase got=%0d want=0", phase); bad++; end
      total++;
      if (ns_light !== 2'b00 || ew_light !== 2'b00) begin
         $display("FAIL reset_lights got=%0d/%0d want=0/0", ns_light, ew_light); bad++;
      end
      total++;
      if (ped_walk !== 1'b0) begin $display("FAIL reset_walk got=%0d want=0", ped_walk); bad++; end
      total++;
      if (dut.ns_req_q !== 1'b0 || dut.ew_req_q !== 1'b0 || dut.ped_req_q !== 1'b0) begin
         $display("FAIL reset_latches got=%0d%0d%0d want=000", dut.ns_req_q, dut.ew_req_q, dut.ped_req_q); bad++;
      end
      total++;
      if (dut.timer_q !== '0) begin $display("FAIL reset_timer got=%0d want=0", dut.timer_q); bad++; end
   endtask

   task automatic test_resting_green();
      int exp;
      do_reset();
      for (int c = 0; c <= 200; c++) begin
         exp = (c < 2) ? P_ARNS : P_NSG;
         total++;
         if (phase !== 3'(exp) || ns_light !== ns_of(exp) || ew_light !== ew_of(exp)) begin
            $display("FAIL resting cyc=%0d got ph=%0d ns=%0d ew=%0d want ph=%0d", c, phase, ns_light, ew_light, exp); bad++;
         end
         tick();
      end
   endtask

   task automatic test_ew_demand();
      int exp;
      do_reset();
      for (int c = 0; c <= 32; c++) begin
         ew_sensor = (c >= 20);
         exp = (c < 2) ? P_ARNS : (c < 22) ? P_NSG : (c < 25) ? P_NSY : (c < 27) ? P_AREW : P_EWG;
         total++;
         if (phase !== 3'(exp) || ns_light !== ns_of(exp) || ew_light !== ew_of(exp)) begin
            $display("FAIL ew_demand cyc=%0d got ph=%0d ns=%0d ew=%0d want ph=%0d", c, phase, ns_light, ew_light, exp); bad++;
         end
         if (c == 21) begin
            total++;
            if (dut.ew_req_q !== 1'b1) begin $display("FAIL ew_req_set got=%0d want=1", dut.ew_req_q); bad++; end
         end
         if (c == 27) begin
            total++;
            if (dut.ew_req_q !== 1'b0) begin $display("FAIL ew_req_clear got=%0d want=0", dut.ew_req_q); bad++; end
         end
         tick();
      end
      ew_sensor = 1'b0;
   endtask

   task automatic test_min_green();
      int exp;
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         ew_sensor = 1'b1;
         exp = (c < 2) ? P_ARNS : (c < 10) ? P_NSG : P_NSY;
         total++;
         if (phase !== 3'(exp)) begin $display("FAIL min_green cyc=%0d got=%0d want=%0d", c, phase, exp); bad++; end
         tick();
      end
      ew_sensor = 1'b0;
   endtask

   task automatic test_max_green();
      int exp;
      do_reset();
      for (int c = 0; c <= 42; c++) begin
         ns_sensor = 1'b1;
         ew_sensor = (c == 5);
         exp = (c < 2) ? P_ARNS : (c < 34) ? P_NSG : (c < 37) ? P_NSY : (c < 39) ? P_AREW : P_EWG;
         total++;
         if (phase !== 3'(exp) || ns_light !== ns_of(exp) || ew_light !== ew_of(exp)) begin
            $display("FAIL max_green cyc=%0d got ph=%0d ns=%0d ew=%0d want ph=%0d", c, phase, ns_light, ew_light, exp); bad++;
         end
         tick();
      end
      ns_sensor = 1'b0;
   endtask

`ifdef PED_CROSSING_EN
   task automatic test_pedestrian();
      int exp;
      do_reset();
      for (int c = 0; c <= 36; c++) begin
         ped_button = (c == 20);
         exp = (c < 2) ? P_ARNS : (c < 22) ? P_NSG : (c < 25) ? P_NSY : (c < 31) ? P_WALK : (c < 33) ? P_AREW : P_EWG;
         total++;
         if (phase !== 3'(exp) || ns_light !== ns_of(exp) || ew_light !== ew_of(exp) || ped_walk !== (exp == P_WALK)) begin
            $display("FAIL pedestrian cyc=%0d got ph=%0d ns=%0d ew=%0d walk=%0d want ph=%0d", c, phase, ns_light, ew_light, ped_walk, exp); bad++;
         end
         tick();
      end
      ped_button = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      int exp;
      do_reset();
      for (int c = 0; c <= 45; c++) begin
         ew_sensor = (c == 0);
         ns_sensor = (c == 16);
         reset = (c == 24);
         if (c == 23 || c == 24) begin
            total++;
            if (phase !== 3'(P_EWY)) begin $display("FAIL pre_reset_ewy cyc=%0d got=%0d want=5", c, phase); bad++; end
         end
         if (c == 24) begin
            total++;
            if (dut.ns_req_q !== 1'b1) begin $display("FAIL pre_reset_nsreq got=%0d want=1", dut.ns_req_q); bad++; end
         end
         if (c == 25) begin
            total++;
            if (ns_light !== 2'b00 || ew_light !== 2'b00 || ped_walk !== 1'b0) begin
               $display("FAIL midreset_lights got=%0d/%0d/%0d want=0/0/0", ns_light, ew_light, ped_walk); bad++;
            end
            total++;
            if (dut.ns_req_q !== 1'b0 || dut.ew_req_q !== 1'b0 || dut.ped_req_q !== 1'b0 || dut.timer_q !== '0) begin
               $display("FAIL midreset_state got=%0d%0d%0d t=%0d want=000 t=0", dut.ns_req_q, dut.ew_req_q, dut.ped_req_q, dut.timer_q); bad++;
            end
         end
         if (c >= 25) begin
            exp = (c < 27) ? P_ARNS : P_NSG;
            total++;
            if (phase !== 3'(exp)) begin $display("FAIL midreset_seq cyc=%0d got=%0d want=%0d", c, phase, exp); bad++; end
         end
         tick();
      end
      reset = 1'b0;
   endtask

   // Randomized sensor/button traffic with occasional resets, checked every cycle against the model.
   task automatic test_random();
      int ns_p, ew_p;
      bit pb;
      do_reset();
      model_reset();
      for (int c = 0; c < 6000; c++) begin
         if (c % 300 == 0) begin
            ns_p = $urandom_range(0, 99);
            ew_p = $urandom_range(0, 99);
         end
         total++;
         if (phase !== 3'(m_ph) || ns_light !== ns_of(m_ph) || ew_light !== ew_of(m_ph) || ped_walk !== (m_ph == P_WALK)) begin
            $display("FAIL random cyc=%0d got ph=%0d ns=%0d ew=%0d walk=%0d want ph=%0d", c, phase, ns_light, ew_light, ped_walk, m_ph); bad++;
         end
         if ($urandom_range(0, 19) == 0) ns_sensor = ($urandom_range(0, 99) < ns_p);
         if ($urandom_range(0, 19) == 0) ew_sensor = ($urandom_range(0, 99) < ew_p);
`ifdef PED_CROSSING_EN
         ped_button = ($urandom_range(0, 99) < 2);
         pb = ped_button;
`else
         pb = 1'b0;
`endif
         reset = ($urandom_range(0, 499) == 0);
         if (reset) model_reset();
         else model_step(ns_sensor, ew_sensor, pb);
         tick();
      end
      reset = 1'b0;
      ns_sensor = 1'b0;
      ew_sensor = 1'b0;
      ped_button = 1'b0;
   endtask

   initial begin
      test_reset();
      test_resting_green();
      test_ew_demand();
      test_min_green();
      test_max_green();
`ifdef PED_CROSSING_EN
      test_pedestrian();
`endif
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
